draw_controller: RTL
====================

// Module: draw_controller
// PURPOSE
//  Sequences one screen redraw: background fill from drawBackground, then lander sprite overlay.
//  Muxes both pixel streams into a single registered plot port for the VGA adapter.
//  Aligns background x/y with the 1-cycle-latency ROM colour. Latches the level for the whole draw.
// PARAMETERS
//  X_SCREEN_PIXELS   160      screen width (x range 0..159)
//  Y_SCREEN_PIXELS   120      screen height (y range 0..119)
//  CYCLES_PER_FRAME  833333   clock cycles per 60 Hz frame at 50 MHz (used only when pacing is enabled)
// PORTS
//  Clock             in   1  system clock, rising edge
//  Reset             in   1  asynchronous, active-low
//  start             in   1  redraw request (pulse or level); sampled only in IDLE
//  levelIn           in   3  0=start screen, 1..3=levels, 4=finish screen
//  currentLevel      out  3  level latched at draw start; drives drawBackground
//  backgroundSignal  out  1  held high for the whole background phase
//  backgroundDone    in   1  from drawBackground
//  backgroundX       in   8  background pixel address x
//  backgroundY       in   7  background pixel address y
//  backgroundColour  in   3  ROM colour, valid 1 cycle after its x/y
//  spriteSignal      out  1  held high for the whole sprite phase
//  spriteDone        in   1  from sprite drawer
//  spriteX           in   8  sprite pixel x, same cycle as spriteValid
//  spriteY           in   7  sprite pixel y, same cycle as spriteValid
//  spriteColour      in   3  sprite colour, same cycle as spriteValid
//  spriteValid       in   1  sprite pixel is opaque and must be plotted
//  vgaX              out  8  plot x
//  vgaY              out  7  plot y
//  vgaColour         out  3  plot colour
//  vgaPlot           out  1  write enable to VGA adapter
//  busy              out  1  high in every state except IDLE
//  frameDone         out  1  1-cycle pulse when a redraw completes
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE; all outputs 0; pipeline registers 0.
//   Reset mid-draw aborts; backgroundSignal/spriteSignal drop, so the drawers clear themselves.
//  FSM: IDLE -> BG_DRAW -> BG_FLUSH -> SPR_DRAW -> DONE -> IDLE.
//   IDLE: on start=1, latch currentLevel<=levelIn and go to BG_DRAW. levelIn>4 is clamped to 4.
//   BG_DRAW: backgroundSignal=1. When backgroundDone=1, drop backgroundSignal and go to BG_FLUSH.
//   BG_FLUSH: exactly 1 cycle to drain the pipeline.
//    Next state is SPR_DRAW if currentLevel is 1..3; otherwise DONE (no sprite on start/finish screens).
//   SPR_DRAW: spriteSignal=1. When spriteDone=1, drop spriteSignal and go to DONE.
//   DONE: frameDone=1 for 1 cycle, then IDLE.
//  Background pixel path: bgValid = (state==BG_DRAW && !backgroundDone).
//   x/y and bgValid are registered once. At the next edge, vgaX/vgaY <= delayed x/y,
//   vgaColour <= backgroundColour, vgaPlot <= delayed bgValid.
//   The pixel at (0,0) is plotted twice (drawer start cycle); this is accepted.
//   The last pixel (159,119) is plotted during BG_FLUSH.
//  Sprite path: at the next edge, vgaX/vgaY/vgaColour <= spriteX/Y/Colour and
//   vgaPlot <= spriteValid && state==SPR_DRAW.
//   Sprite pixels always overwrite the background because they come later.
//  vgaPlot=0 in IDLE/DONE. vgaX/vgaY/vgaColour hold their last value when vgaPlot=0.
//  start while busy: ignored, not queued. levelIn changes mid-draw: ignored.
//  start and DONE in the same cycle: start ignored; it is accepted the next cycle if still high.
// CONFIGURATION
//  DRAW_FRAME_PACING_EN defined:
//   free-running counter 0..CYCLES_PER_FRAME-1 (20 bits), wraps; frameTick on wrap.
//   A start in IDLE sets a pending flag; the draw begins on the first frameTick with pending=1.
//   pending clears at draw start.
//  Not defined: no counter; start in IDLE begins the draw on the next edge.
// STRUCTURE
//  Package draw_pkg: state encoding (3-bit localparams), X/Y_SCREEN_PIXELS, colour width 3,
//   level codes LVL_START=0 / LVL_FINISH=4.
//  Sub-module plot_pipe: 1-stage register of {x,y,colour,plot} with async active-low reset.
//   Instantiated once, fed by the source mux.
// TESTING
//  1 Reset held, start=1 -> all outputs 0; release -> IDLE, then BG_DRAW 1 cycle after start.
//  2 levelIn=2, ROM model colour=x[2:0]: exactly 19201 vgaPlot pulses in background phase
//    (19200 + duplicate (0,0)); each colour == x[2:0] of the same vgaX.
//  3 levelIn=0 -> no spriteSignal; frameDone 2 cycles after backgroundDone rises.
//  4 levelIn=1, sprite model 4 valid pixels at (80,60..63) colour 3'b111
//    -> those 4 plots last; frameDone follows.
//  5 Reset=0 midway through BG_DRAW (y=50) -> backgroundSignal=0 and vgaPlot=0 immediately;
//    a fresh start redraws from (0,0).
//  6 DRAW_FRAME_PACING_EN, CYCLES_PER_FRAME=100, start at count 10 -> BG_DRAW entered at wrap (~90 cycles later).

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants for the redraw sequencer: FSM state codes, screen geometry,
// colour width, level codes and the plot-port bundle layout.
package draw_pkg;

    localparam int X_SCREEN_PIXELS = 160;
    localparam int Y_SCREEN_PIXELS = 120;
    localparam int X_W             = 8;
    localparam int Y_W             = 7;
    localparam int COLOUR_W        = 3;
    localparam int LEVEL_W         = 3;

    localparam logic [LEVEL_W-1:0] LVL_START  = 3'd0;
    localparam logic [LEVEL_W-1:0] LVL_FINISH = 3'd4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BG_DRAW  = 3'd1;
    localparam logic [2:0] S_BG_FLUSH = 3'd2;
    localparam logic [2:0] S_SPR_DRAW = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
        logic                plot;
    } plot_t;

    // Codes above the finish screen are treated as the finish screen.
    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl);
        return (lvl > LVL_FINISH) ? LVL_FINISH : lvl;
    endfunction

    // Only playable levels carry a lander sprite.
    function automatic logic level_has_sprite(input logic [LEVEL_W-1:0] lvl);
        return (lvl != LVL_START) && (lvl < LVL_FINISH);
    endfunction

endpackage

// File: rtl/plot_pipe.sv
// Single output register stage for the VGA plot port; coordinates and colour
// only update on a plotted pixel so they hold their last value otherwise.
module plot_pipe
    import draw_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_W-1:0]      pix_x,
    input  logic [Y_W-1:0]      pix_y,
    input  logic [COLOUR_W-1:0] pix_colour,
    input  logic                pix_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    plot_t out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
        end else begin
            out_reg.plot <= pix_plot;
            if (pix_plot) begin
                out_reg.x      <= pix_x;
                out_reg.y      <= pix_y;
                out_reg.colour <= pix_colour;
            end
        end
    end

    assign vga_x      = out_reg.x;
    assign vga_y      = out_reg.y;
    assign vga_colour = out_reg.colour;
    assign vga_plot   = out_reg.plot;

endmodule

// File: rtl/draw_controller.sv
// Redraw sequencer: background fill, then lander sprite, muxed onto one registered
// plot port. Optional frame pacing is enabled with `define DRAW_FRAME_PACING_EN.
module draw_controller
    import draw_pkg::*;
#(
    parameter int CYCLES_PER_FRAME = 833333
)
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [LEVEL_W-1:0]  levelIn,
    output logic [LEVEL_W-1:0]  currentLevel,
    output logic                backgroundSignal,
    input  logic                backgroundDone,
    input  logic [X_W-1:0]      backgroundX,
    input  logic [Y_W-1:0]      backgroundY,
    input  logic [COLOUR_W-1:0] backgroundColour,
    output logic                spriteSignal,
    input  logic                spriteDone,
    input  logic [X_W-1:0]      spriteX,
    input  logic [Y_W-1:0]      spriteY,
    input  logic [COLOUR_W-1:0] spriteColour,
    input  logic                spriteValid,
    output logic [X_W-1:0]      vgaX,
    output logic [Y_W-1:0]      vgaY,
    output logic [COLOUR_W-1:0] vgaColour,
    output logic                vgaPlot,
    output logic                busy,
    output logic                frameDone
);

    logic [2:0]          state_reg;
    logic [2:0]          state_next;
    logic [LEVEL_W-1:0]  level_reg;
    logic                launch;

    logic [X_W-1:0]      bg_x_reg;
    logic [Y_W-1:0]      bg_y_reg;
    logic                bg_valid_reg;

    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                pix_plot;

`ifdef DRAW_FRAME_PACING_EN
    localparam logic [19:0] FRAME_LAST = 20'(CYCLES_PER_FRAME - 1);

    logic [19:0] frame_cnt_reg;
    logic        frame_tick;
    logic        pending_reg;

    assign frame_tick = (frame_cnt_reg == FRAME_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            frame_cnt_reg <= '0;
        end else if (frame_tick) begin
            frame_cnt_reg <= '0;
        end else begin
            frame_cnt_reg <= frame_cnt_reg + 20'd1;
        end
    end

    // A request arriving on the tick cycle itself launches straight away.
    assign launch = frame_tick && (pending_reg || start);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pending_reg <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (launch) begin
                pending_reg <= 1'b0;
            end else if (start) begin
                pending_reg <= 1'b1;
            end
        end
    end
`else
    localparam int unused_frame_cycles = CYCLES_PER_FRAME;

    assign launch = start;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (launch) state_next = S_BG_DRAW;
            S_BG_DRAW:  if (backgroundDone) state_next = S_BG_FLUSH;
            S_BG_FLUSH: state_next = level_has_sprite(level_reg) ? S_SPR_DRAW : S_DONE;
            S_SPR_DRAW: if (spriteDone) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            level_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && start) begin
                level_reg <= clamp_level(levelIn);
            end
        end
    end

    // Delay the background address one cycle so it lines up with the ROM colour.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bg_x_reg     <= '0;
            bg_y_reg     <= '0;
            bg_valid_reg <= 1'b0;
        end else begin
            bg_x_reg     <= backgroundX;
            bg_y_reg     <= backgroundY;
            bg_valid_reg <= (state_reg == S_BG_DRAW) && !backgroundDone;
        end
    end

    always_comb begin
        pix_x      = bg_x_reg;
        pix_y      = bg_y_reg;
        pix_colour = backgroundColour;
        pix_plot   = bg_valid_reg;
        if (state_reg == S_SPR_DRAW) begin
            pix_x      = spriteX;
            pix_y      = spriteY;
            pix_colour = spriteColour;
            pix_plot   = spriteValid;
        end
    end

    plot_pipe u_plot_pipe (
        .clk        (Clock),
        .rst_n      (Reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_plot   (pix_plot),
        .vga_x      (vgaX),
        .vga_y      (vgaY),
        .vga_colour (vgaColour),
        .vga_plot   (vgaPlot)
    );

    assign currentLevel     = level_reg;
    assign backgroundSignal = (state_reg == S_BG_DRAW);
    assign spriteSignal     = (state_reg == S_SPR_DRAW);
    assign busy             = (state_reg != S_IDLE);
    assign frameDone        = (state_reg == S_DONE);

endmodule
